// File: rtl/i3c_bus_input_conditioner.sv
// ---------------------------------------------------------------------------
// i3c_bus_input_conditioner
//
// Conditions the raw SCL/SDA pad levels for the I3C core. It synchronises
// both lines into clk_i and can optionally filter spikes. It also produces
// registered single-cycle bus events (SCL edges, START/Repeated START, STOP)
// and keeps bus-free / bus-idle status from a shared saturating timer.
//
// Optional feature macro: I3C_SPIKE_FILTER_EN
//   defined   : per-line spike filter (FilterCycles stable cycles required)
//   undefined : conditioned level is the synchronised level, no filter logic
//
// Parameters:
//   SyncStages    synchroniser flops per line (>= 2)
//   FilterCycles  stable cycles needed before a new level is accepted (>= 1)
//   BusFreeCycles SCL=SDA=1 cycles after STOP/reset before bus_free_o
//   BusIdleCycles SCL=SDA=1 cycles after STOP/reset before bus_idle_o
//                 (>= BusFreeCycles)
//
// Ports:
//   clk_i        clock
//   rst_i        synchronous active-high reset
//   scl_i/sda_i  raw pad levels
//   scl_o/sda_o  conditioned levels (reset to 1)
//   scl_rise_o   one-cycle pulse with the conditioned SCL rising edge
//   scl_fall_o   one-cycle pulse with the conditioned SCL falling edge
//   start_det_o  one-cycle pulse on START / Repeated START
//   stop_det_o   one-cycle pulse on STOP
//   bus_free_o   bus-free condition
//   bus_idle_o   bus-idle condition
// ---------------------------------------------------------------------------
module i3c_bus_input_conditioner #(
    parameter int unsigned SyncStages    = 2,
    parameter int unsigned FilterCycles  = 3,
    parameter int unsigned BusFreeCycles = 8,
    parameter int unsigned BusIdleCycles = 20
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_o,
    output logic sda_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_det_o,
    output logic stop_det_o,
    output logic bus_free_o,
    output logic bus_idle_o
);

    if (SyncStages < 2 || FilterCycles < 1 || BusIdleCycles < BusFreeCycles) begin : g_param_check
        $error("i3c_bus_input_conditioner: illegal parameter combination");
    end

    localparam int unsigned CW = $clog2(BusIdleCycles + 1);
    localparam logic [CW-1:0] FREE_TH = CW'(BusFreeCycles);
    localparam logic [CW-1:0] IDLE_TH = CW'(BusIdleCycles);

    // ------------------------------------------------------------------
    // Synchroniser: lines idle high on pull-ups, so every stage resets to 1
    // ------------------------------------------------------------------
    logic [SyncStages-1:0] scl_sync;
    logic [SyncStages-1:0] sda_sync;
    logic                  scl_s;
    logic                  sda_s;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            scl_sync <= '1;
            sda_sync <= '1;
        end else begin
            scl_sync <= {scl_sync[SyncStages-2:0], scl_i};
            sda_sync <= {sda_sync[SyncStages-2:0], sda_i};
        end
    end

    assign scl_s = scl_sync[SyncStages-1];
    assign sda_s = sda_sync[SyncStages-1];

    // ------------------------------------------------------------------
    // Conditioned level f and its next-edge value. Edge/event detection
    // compares the next value against the current one, so every pulse is
    // registered on the same edge that updates scl_o/sda_o.
    // ------------------------------------------------------------------
    logic scl_f;
    logic sda_f;
    logic scl_next;
    logic sda_next;

`ifdef I3C_SPIKE_FILTER_EN
    localparam int unsigned FW = $clog2(FilterCycles + 1);
    // The counter "would reach" FilterCycles when it currently holds FilterCycles-1
    localparam logic [FW-1:0] FILT_LAST = FW'(FilterCycles - 1);

    logic [FW-1:0] scl_cnt;
    logic [FW-1:0] sda_cnt;
    logic          scl_flt;
    logic          sda_flt;

    always_comb begin
        scl_next = scl_flt;
        sda_next = sda_flt;
        if (scl_s != scl_flt && scl_cnt == FILT_LAST) begin
            scl_next = scl_s;
        end
        if (sda_s != sda_flt && sda_cnt == FILT_LAST) begin
            sda_next = sda_s;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            scl_flt <= 1'b1;
            sda_flt <= 1'b1;
            scl_cnt <= '0;
            sda_cnt <= '0;
        end else begin
            scl_flt <= scl_next;
            sda_flt <= sda_next;
            if (scl_s == scl_flt || scl_cnt == FILT_LAST) begin
                scl_cnt <= '0;
            end else begin
                scl_cnt <= scl_cnt + 1'b1;
            end
            if (sda_s == sda_flt || sda_cnt == FILT_LAST) begin
                sda_cnt <= '0;
            end else begin
                sda_cnt <= sda_cnt + 1'b1;
            end
        end
    end

    assign scl_f = scl_flt;
    assign sda_f = sda_flt;
`else
    // Without the filter the last synchroniser stage is the conditioned
    // level, and the stage feeding it is therefore its next value.
    assign scl_f    = scl_s;
    assign sda_f    = sda_s;
    assign scl_next = scl_sync[SyncStages-2];
    assign sda_next = sda_sync[SyncStages-2];
`endif

    // ------------------------------------------------------------------
    // Bus events
    // ------------------------------------------------------------------
    logic scl_rise_n;
    logic scl_fall_n;
    logic sda_rise_n;
    logic sda_fall_n;
    logic scl_high_steady;
    logic start_n;
    logic stop_n;

    always_comb begin
        scl_rise_n      = scl_next & ~scl_f;
        scl_fall_n      = ~scl_next & scl_f;
        sda_rise_n      = sda_next & ~sda_f;
        sda_fall_n      = ~sda_next & sda_f;
        // START/STOP only when SCL is high and not changing in the same cycle
        scl_high_steady = scl_f & scl_next;
        start_n         = scl_high_steady & sda_fall_n;
        stop_n          = scl_high_steady & sda_rise_n;
    end

    // ------------------------------------------------------------------
    // Free/idle timer
    // ------------------------------------------------------------------
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;
    logic          armed;
    logic          armed_n;
    logic          free_n;
    logic          idle_n;

    always_comb begin
        cnt_n   = cnt;
        armed_n = armed;
        if (start_n || scl_fall_n || sda_fall_n) begin
            armed_n = 1'b0;
            cnt_n   = '0;
        end else if (stop_n) begin
            armed_n = 1'b1;
            cnt_n   = '0;
        end else if (armed && scl_next && sda_next && cnt != IDLE_TH) begin
            cnt_n = cnt + 1'b1;
        end
        free_n = armed_n && (cnt_n >= FREE_TH);
        idle_n = armed_n && (cnt_n >= IDLE_TH);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt         <= '0;
            armed       <= 1'b1;
            scl_rise_o  <= 1'b0;
            scl_fall_o  <= 1'b0;
            start_det_o <= 1'b0;
            stop_det_o  <= 1'b0;
            bus_free_o  <= 1'b0;
            bus_idle_o  <= 1'b0;
        end else begin
            cnt         <= cnt_n;
            armed       <= armed_n;
            scl_rise_o  <= scl_rise_n;
            scl_fall_o  <= scl_fall_n;
            start_det_o <= start_n;
            stop_det_o  <= stop_n;
            bus_free_o  <= free_n;
            bus_idle_o  <= idle_n;
        end
    end

    assign scl_o = scl_f;
    assign sda_o = sda_f;

endmodule
